// File: rtl/alu_op_sequencer.sv
// Purpose: registered RV32I(+M) ALU-op decoder between ID and EX, one-entry output register.
// Latency: single-cycle ops valid the cycle after accept; M ops valid MUL_LAT/DIV_LAT cycles after accept.
// Backpressure: valid/ready both sides; FULL holds all outputs while out_ready=0, in_ready=0 while BUSY.
// Config: define RV32M_EN to decode the M extension (funct7 0000001) onto the multi-cycle path.
module alu_op_sequencer #(
  parameter int ALU_OP_W = 5,
  parameter int MUL_LAT  = 2,
  parameter int DIV_LAT  = 33,
  parameter int CNT_W    = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         instruction,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALU_OP_W-1:0] out_alu_op,
  output logic                out_use_imm,
  output logic                out_is_branch,
  output logic                out_multi,
  output logic                out_illegal,
  output logic                busy
);

  // Major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  // ALU op codes
  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_SLL   = 5'd2;
  localparam logic [4:0] OP_SLT   = 5'd3;
  localparam logic [4:0] OP_SLTU  = 5'd4;
  localparam logic [4:0] OP_XOR   = 5'd5;
  localparam logic [4:0] OP_SRL   = 5'd6;
  localparam logic [4:0] OP_SRA   = 5'd7;
  localparam logic [4:0] OP_OR    = 5'd8;
  localparam logic [4:0] OP_AND   = 5'd9;
  localparam logic [4:0] OP_BEQ   = 5'd10;
  localparam logic [4:0] OP_BNE   = 5'd11;
  localparam logic [4:0] OP_BLT   = 5'd12;
  localparam logic [4:0] OP_BGE   = 5'd13;
  localparam logic [4:0] OP_BLTU  = 5'd14;
  localparam logic [4:0] OP_BGEU  = 5'd15;
`ifdef RV32M_EN
  localparam logic [4:0] OP_MUL   = 5'd16;
`endif
  localparam logic [4:0] OP_PASSB = 5'd24;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   next_cnt;
  logic               accept;

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic [4:0]         dec_op;
  logic               dec_imm;
  logic               dec_br;
  logic               dec_multi;
  logic               dec_ill;
  logic [CNT_W-1:0]   dec_lat;
  state_t             load_state;
  logic [CNT_W-1:0]   load_cnt;

  // Register-number fields do not affect the ALU op.
  logic               unused_bits;

  assign opcode      = instruction[6:0];
  assign funct3      = instruction[14:12];
  assign funct7      = instruction[31:25];
  assign unused_bits = ^{instruction[24:15], instruction[11:7]};

  // Decode the instruction word into op, side flags and result latency.
  always_comb begin
    dec_op    = OP_ADD;
    dec_imm   = 1'b0;
    dec_br    = 1'b0;
    dec_multi = 1'b0;
    dec_ill   = 1'b0;
    dec_lat   = CNT_W'(1);
    case (opcode)
      OPC_OP: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000: dec_op = OP_ADD;
            3'b001: dec_op = OP_SLL;
            3'b010: dec_op = OP_SLT;
            3'b011: dec_op = OP_SLTU;
            3'b100: dec_op = OP_XOR;
            3'b101: dec_op = OP_SRL;
            3'b110: dec_op = OP_OR;
            3'b111: dec_op = OP_AND;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_op = OP_SUB;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          dec_op = OP_SRA;
`ifdef RV32M_EN
        end else if (funct7 == 7'b0000001) begin
          // funct3[2] splits the multiplier group from the divider group
          dec_op    = OP_MUL + {2'b00, funct3};
          dec_multi = 1'b1;
          dec_lat   = funct3[2] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
`endif
        end else begin
          dec_ill = 1'b1;
        end
      end
      OPC_IMM: begin
        dec_imm = 1'b1;
        case (funct3)
          3'b000: dec_op = OP_ADD;
          3'b010: dec_op = OP_SLT;
          3'b011: dec_op = OP_SLTU;
          3'b100: dec_op = OP_XOR;
          3'b110: dec_op = OP_OR;
          3'b111: dec_op = OP_AND;
          3'b001: begin
            if (funct7 == 7'b0000000) dec_op = OP_SLL;
            else                      dec_ill = 1'b1;
          end
          3'b101: begin
            // bit 30 selects arithmetic shift; every other funct7 bit must be zero
            if ({funct7[6], funct7[4:0]} == 6'b000000)
              dec_op = instruction[30] ? OP_SRA : OP_SRL;
            else
              dec_ill = 1'b1;
          end
        endcase
      end
      OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR, OPC_AUIPC: begin
        dec_op  = OP_ADD;
        dec_imm = 1'b1;
      end
      OPC_LUI: begin
        dec_op  = OP_PASSB;
        dec_imm = 1'b1;
      end
      OPC_BRANCH: begin
        dec_br = 1'b1;
        case (funct3)
          3'b000:  dec_op = OP_BEQ;
          3'b001:  dec_op = OP_BNE;
          3'b100:  dec_op = OP_BLT;
          3'b101:  dec_op = OP_BGE;
          3'b110:  dec_op = OP_BLTU;
          3'b111:  dec_op = OP_BGEU;
          default: dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
    // Anything undecodable leaves as a plain single-cycle ADD flagged illegal.
    if (dec_ill) begin
      dec_op    = OP_ADD;
      dec_imm   = 1'b0;
      dec_br    = 1'b0;
      dec_multi = 1'b0;
      dec_lat   = CNT_W'(1);
    end
  end

  // Where a freshly accepted op goes: straight to FULL, or count down in BUSY.
  always_comb begin
    load_state = ST_FULL;
    load_cnt   = '0;
    if (dec_lat > CNT_W'(1)) begin
      load_state = ST_BUSY;
      load_cnt   = dec_lat - CNT_W'(1);
    end
  end

  // Handshake outputs and next state; flush overrides everything but reset.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      ST_EMPTY: in_ready = 1'b1;
      ST_FULL: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      ST_BUSY:  busy = 1'b1;
      default:  ;
    endcase
`ifndef RV32M_EN
    busy = 1'b0;
`endif
    if (reset || flush) in_ready = 1'b0;
    accept = in_valid & in_ready;

    if (flush) begin
      next_state = ST_EMPTY;
      next_cnt   = '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            next_state = load_state;
            next_cnt   = load_cnt;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            if (accept) begin
              next_state = load_state;
              next_cnt   = load_cnt;
            end else begin
              next_state = ST_EMPTY;
            end
          end
        end
        ST_BUSY: begin
          next_cnt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) next_state = ST_FULL;
        end
        default: begin
          next_state = ST_EMPTY;
          next_cnt   = '0;
        end
      endcase
    end
  end

  // State and countdown register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_EMPTY;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Decoded fields are captured only on accept, so they stay put through BUSY and stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_alu_op    <= '0;
      out_use_imm   <= 1'b0;
      out_is_branch <= 1'b0;
      out_multi     <= 1'b0;
      out_illegal   <= 1'b0;
    end else if (accept) begin
      out_alu_op    <= ALU_OP_W'(dec_op);
      out_use_imm   <= dec_imm;
      out_is_branch <= dec_br;
      out_multi     <= dec_multi;
      out_illegal   <= dec_ill;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed vectors, cycle-level reference model and hand-computed checks.
// Works with or without RV32M_EN defined.
module tb_alu_op_sequencer;
  localparam int ALU_OP_W = 5;
  localparam int MUL_LAT  = 2;
  localparam int DIV_LAT  = 33;
  localparam int CNT_W    = 6;
  localparam int NVEC     = 41;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic out_use_imm, out_is_branch, out_multi, out_illegal, busy;
  logic [31:0] instruction;
  logic [ALU_OP_W-1:0] out_alu_op;

  int n_checks = 0;
  int n_fail   = 0;
  bit rand_rdy = 1'b0;

  // reference model state
  bit m_has = 1'b0;
  int m_due = 0;
  int cyc   = 0;
  int m_op;
  bit m_imm, m_br, m_multi, m_ill;

  logic [31:0] vec [0:NVEC-1];

  always #5 clk = ~clk;

  alu_op_sequencer #(.ALU_OP_W(ALU_OP_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_op(out_alu_op), .out_use_imm(out_use_imm), .out_is_branch(out_is_branch),
    .out_multi(out_multi), .out_illegal(out_illegal), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected decode from the ISA tables.
  function automatic void model_decode(input logic [31:0] ins, output int op, output bit imm,
                                       output bit br, output bit multi, output bit ill, output int lat);
    int opc, f3, f7;
    int r_ops [8];
    int b_ops [8];
    bit m_en;
`ifdef RV32M_EN
    m_en = 1'b1;
`else
    m_en = 1'b0;
`endif
    r_ops = '{0, 2, 3, 4, 5, 6, 8, 9};
    b_ops = '{10, 11, -1, -1, 12, 13, 14, 15};
    opc = int'(ins[6:0]);
    f3  = int'(ins[14:12]);
    f7  = int'(ins[31:25]);
    op = 0; imm = 0; br = 0; multi = 0; ill = 0; lat = 1;
    case (opc)
      'h33: begin
        if (f7 == 0) op = r_ops[f3];
        else if (f7 == 'h20 && f3 == 0) op = 1;
        else if (f7 == 'h20 && f3 == 5) op = 7;
        else if (m_en && f7 == 1) begin
          op = 16 + f3; multi = 1; lat = (f3 < 4) ? MUL_LAT : DIV_LAT;
        end else ill = 1;
      end
      'h13: begin
        imm = 1;
        if (f3 == 1) begin
          if (f7 == 0) op = 2; else ill = 1;
        end else if (f3 == 5) begin
          if (f7 == 0) op = 6; else if (f7 == 'h20) op = 7; else ill = 1;
        end else op = r_ops[f3];
      end
      'h03, 'h23, 'h6F, 'h67, 'h17: begin op = 0; imm = 1; end
      'h37: begin op = 24; imm = 1; end
      'h63: begin
        br = 1; op = b_ops[f3];
        if (op < 0) ill = 1;
      end
      default: ill = 1;
    endcase
    if (ill) begin op = 0; imm = 0; br = 0; multi = 0; lat = 1; end
  endfunction

  // Model advance at each clock edge: one op in flight, due 'lat' cycles after its accept.
  always @(posedge clk) begin
    int op, lat;
    bit i_f, b_f, mu_f, il_f, consumed;
    if (reset || flush) begin
      m_has = 1'b0;
    end else begin
      consumed = m_has && (cyc >= m_due) && out_ready;
      if (in_valid && (!m_has || consumed)) begin
        model_decode(instruction, op, i_f, b_f, mu_f, il_f, lat);
        m_has = 1'b1; m_due = cyc + lat;
        m_op = op; m_imm = i_f; m_br = b_f; m_multi = mu_f; m_ill = il_f;
      end else if (consumed) begin
        m_has = 1'b0;
      end
    end
    cyc++;
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    bit e_valid, e_busy, e_rdy;
    if (reset) begin
      m_has = 1'b0;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fields", {out_alu_op, out_use_imm, out_is_branch, out_multi, out_illegal}, 0);
    end else begin
      e_valid = m_has && (cyc >= m_due);
      e_busy  = m_has && (cyc < m_due);
      e_rdy   = !flush && (!m_has || (e_valid && out_ready));
      chk("mdl_out_valid", out_valid, e_valid);
      chk("mdl_busy", busy, e_busy);
      chk("mdl_in_ready", in_ready, e_rdy);
      if (m_has) begin
        chk("mdl_alu_op", out_alu_op, m_op);
        chk("mdl_use_imm", out_use_imm, m_imm);
        chk("mdl_is_branch", out_is_branch, m_br);
        chk("mdl_multi", out_multi, m_multi);
        chk("mdl_illegal", out_illegal, m_ill);
      end
    end
  end

  // Random output backpressure window.
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction and wait (bounded) until it is taken.
  task automatic send(input logic [31:0] ins);
    bit done;
    done = 1'b0;
    instruction = ins;
    in_valid = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      tick();
    end
    chk("accept_in_time", done, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, lat;
    bit i_f, b_f, mu_f, il_f;
    vec = '{32'h003100B3, 32'h403100B3, 32'h003110B3, 32'h003120B3, 32'h003130B3, 32'h003140B3,
            32'h003150B3, 32'h403150B3, 32'h003160B3, 32'h003170B3, 32'h00310093, 32'h00312093,
            32'h00313093, 32'h00314093, 32'h00316093, 32'h00317093, 32'h00309093, 32'h0030D093,
            32'h4030D093, 32'h40309093, 32'h00012083, 32'h00112023, 32'h008000EF, 32'h000100E7,
            32'h00001097, 32'h000010B7, 32'h00208063, 32'h00209063, 32'h0020C063, 32'h0020D063,
            32'h0020E063, 32'h0020F063, 32'h0020A063, 32'h0000007F, 32'h803100B3, 32'h403110B3,
            32'h022081B3, 32'h0220B1B3, 32'h0220C1B3, 32'h0220F1B3, 32'h6030D093};

    reset = 1'b1; in_valid = 1'b0; instruction = '0; flush = 1'b0; out_ready = 1'b1;
    #2;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Pin the model with hand-decoded literals.
    model_decode(32'h003100B3, op, i_f, b_f, mu_f, il_f, lat);
    chk("lit_add_op", op, 0);
    chk("lit_add_imm", i_f, 0);
    model_decode(32'h4030D093, op, i_f, b_f, mu_f, il_f, lat);
    chk("lit_srai_op", op, 7);
    chk("lit_srai_imm", i_f, 1);
    model_decode(32'h0020F063, op, i_f, b_f, mu_f, il_f, lat);
    chk("lit_bgeu_op", op, 15);
    chk("lit_bgeu_br", b_f, 1);
    model_decode(32'h0220C1B3, op, i_f, b_f, mu_f, il_f, lat);
`ifdef RV32M_EN
    chk("lit_div_op", op, 20);
    chk("lit_div_lat", lat, 33);
`else
    chk("lit_div_op", op, 0);
    chk("lit_div_ill", il_f, 1);
`endif

    // Pass 1: every vector back-to-back, EX always ready.
    for (int i = 0; i < NVEC; i++) begin
      send(vec[i]);
      if (i == 0) begin
        chk("add_valid", out_valid, 1);
        chk("add_op", out_alu_op, 0);
        chk("add_imm", out_use_imm, 0);
      end
      if (i == 18) begin
        chk("srai_op", out_alu_op, 7);
        chk("srai_imm", out_use_imm, 1);
      end
      if (i == 31) begin
        chk("bgeu_op", out_alu_op, 15);
        chk("bgeu_br", out_is_branch, 1);
      end
    end
    in_valid = 1'b0;
    repeat (40) tick();

    // Backpressure: 5 stalled cycles, then back-to-back accept.
    send(32'h003140B3);
    out_ready = 1'b0;
    instruction = 32'h003170B3;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_op", out_alu_op, 5);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_rdy", in_ready, 1);
    tick();
    chk("b2b_valid", out_valid, 1);
    chk("b2b_op", out_alu_op, 9);
    in_valid = 1'b0;
    repeat (2) tick();

    // Flush while FULL.
    out_ready = 1'b0;
    send(32'h403100B3);
    in_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_full_rdy", in_ready, 0);
    tick();
    flush = 1'b0;
    chk("flush_full_valid", out_valid, 0);
    out_ready = 1'b1;
    tick();

    // MUL encoding.
    send(32'h022081B3);
    in_valid = 1'b0;
`ifdef RV32M_EN
    chk("mul_busy", busy, 1);
    chk("mul_valid_early", out_valid, 0);
    tick();
    chk("mul_valid", out_valid, 1);
    chk("mul_op", out_alu_op, 16);
    chk("mul_multi", out_multi, 1);
`else
    chk("mul_valid", out_valid, 1);
    chk("mul_op", out_alu_op, 0);
    chk("mul_illegal", out_illegal, 1);
    chk("mul_busy", busy, 0);
`endif
    repeat (2) tick();

`ifdef RV32M_EN
    // DIV: busy for 32 cycles, valid on the 33rd after accept.
    send(32'h0220C1B3);
    in_valid = 1'b0;
    for (int j = 1; j <= 32; j++) begin
      @(negedge clk);
      chk("div_busy", {busy, out_valid, in_ready}, 3'b100);
      tick();
    end
    chk("div_valid", out_valid, 1);
    chk("div_op", out_alu_op, 20);
    chk("div_multi", out_multi, 1);
    tick();

    // Flush with 10 cycles of countdown left.
    send(32'h0220C1B3);
    in_valid = 1'b0;
    repeat (22) tick();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_busy_pre", {busy, in_ready}, 2'b10);
    tick();
    flush = 1'b0;
    chk("flush_busy_valid", out_valid, 0);
    chk("flush_busy_busy", busy, 0);
    tick();

    // Asynchronous reset in the middle of BUSY.
    send(32'h0220C1B3);
    in_valid = 1'b0;
    repeat (5) tick();
    #2 reset = 1'b1;
    #1;
    chk("areset_valid", out_valid, 0);
    chk("areset_busy", busy, 0);
    chk("areset_op", out_alu_op, 0);
    chk("areset_multi", out_multi, 0);
`else
    // Asynchronous reset while holding a stalled op.
    out_ready = 1'b0;
    send(32'h000010B7);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("areset_valid", out_valid, 0);
    chk("areset_op", out_alu_op, 0);
    chk("areset_imm", out_use_imm, 0);
`endif
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    tick();

    // Pass 2: same vectors under random EX backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < NVEC; i++) send(vec[i]);
    in_valid = 1'b0;
    repeat (10) tick();
    rand_rdy = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    repeat (40) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
